// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM encoding, mode constants and frame width.
package spi_pkg;

    localparam int SPI_WIDTH = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    // Mode constants in {CKE,CKP} order, same as the master side.
    localparam logic [1:0] IDEAL_ZERO_NORMAL_PHASE   = 2'b00;
    localparam logic [1:0] IDEAL_ONE_NORMAL_PHASE    = 2'b01;
    localparam logic [1:0] IDEAL_ZERO_INVERTED_PHASE = 2'b10;
    localparam logic [1:0] IDEAL_ONE_INVERTED_PHASE  = 2'b11;

    // Sampling happens on rising SCLK when the idle level and phase agree.
    function automatic logic sample_on_rise(input logic ckp, input logic cke);
        return (ckp == cke);
    endfunction

endpackage

// File: rtl/spi_slave_core_if.sv
// Pin and local-bus bundle of the SPI slave core.
interface spi_slave_core_if;
    import spi_pkg::*;

    logic                 CKP;
    logic                 CKE;
    logic                 CS;
    logic                 SCLK;
    logic                 MOSI;
    logic                 MISO;
    logic [SPI_WIDTH-1:0] data_TX;
    logic                 DATA_LOAD;
    logic                 TX_READY;
    logic [SPI_WIDTH-1:0] data_RX;
    logic                 RX_VALID;
    logic                 FRAME_ERR;
    logic                 BUSY;

    modport slave (
        input  CKP, CKE, CS, SCLK, MOSI, data_TX, DATA_LOAD,
        output MISO, TX_READY, data_RX, RX_VALID, FRAME_ERR, BUSY
    );

    modport master (
        output CKP, CKE, CS, SCLK, MOSI, data_TX, DATA_LOAD,
        input  MISO, TX_READY, data_RX, RX_VALID, FRAME_ERR, BUSY
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer followed by a rise/fall detector.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronizer chain plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
            prev_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign q    = sync_r;
    assign rise = sync_r & ~prev_r;
    assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/spi_slave_core.sv
// Byte-oriented SPI slave: oversampled pins, MSB-first shift in/out,
// one-byte TX buffer and one-cycle RX strobe towards local logic.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    spi_slave_core_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    // synchronized pins and edges
    logic cs_q_s, cs_rise_s, cs_fall_s;
    logic sclk_q_s, sclk_rise_s, sclk_fall_s;
    logic mosi_q_s, mosi_rise_s, mosi_fall_s;
    logic unused_s;

    // control
    spi_state_e       state_r, state_next;
    logic             cs_accept_s, sample_do_s, shift_do_s, abort_s;
    logic             byte_done_s, reload_s;
    logic             sample_rise_s, sample_edge_s, shift_edge_s;
    logic [1:0]       settle_r;
    logic             armed_r;
    logic             ckp_r, cke_r, skip_r;
    logic [CNT_W-1:0] bit_cnt_r;

    // data
    logic [WIDTH-1:0] tx_buf_r, tx_sr_r, tx_fill_s;
    logic             tx_ready_r;
    logic [WIDTH-2:0] rx_sr_r;
    logic [WIDTH-1:0] data_rx_r;
    logic             rx_valid_r, frame_err_r, miso_r, busy_r;

    // CS idles high, so its synchronizer starts high.
    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(bus.CS), .q(cs_q_s), .rise(cs_rise_s), .fall(cs_fall_s)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(bus.SCLK), .q(sclk_q_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(bus.MOSI), .q(mosi_q_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
    );

    // Level of SCLK and edges of MOSI are not needed.
    assign unused_s = ^{sclk_q_s, mosi_rise_s, mosi_fall_s};

    assign sample_rise_s = sample_on_rise(ckp_r, cke_r);
    assign sample_edge_s = sample_rise_s ? sclk_rise_s : sclk_fall_s;
    assign shift_edge_s  = sample_rise_s ? sclk_fall_s : sclk_rise_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next state and per-cycle action decode; CS rise outranks SCLK edges.
    always_comb begin
        state_next  = state_r;
        cs_accept_s = 1'b0;
        sample_do_s = 1'b0;
        shift_do_s  = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (cs_fall_s && armed_r) begin
                    state_next  = ACTIVE;
                    cs_accept_s = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            ACTIVE: begin
                if (cs_rise_s) begin
                    state_next = IDLE;
                    abort_s    = (bit_cnt_r != {CNT_W{1'b0}});
                end else if (sample_edge_s) begin
                    sample_do_s = 1'b1;
                end else if (shift_edge_s) begin
                    shift_do_s = 1'b1;
                end else begin
                    state_next = ACTIVE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign byte_done_s = sample_do_s && (bit_cnt_r == CNT_W'(WIDTH - 1));
    assign reload_s    = cs_accept_s || byte_done_s;
    assign tx_fill_s   = tx_ready_r ? {WIDTH{1'b0}} : tx_buf_r;

    // Arm CS-fall acceptance only once the CS synchronizer holds real pin
    // data and shows CS high, so a reset inside a frame waits for a new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_r <= 2'd0;
            armed_r  <= 1'b0;
        end else if (settle_r != 2'd3) begin
            settle_r <= settle_r + 2'd1;
            armed_r  <= 1'b0;
        end else if (cs_q_s) begin
            armed_r <= 1'b1;
        end else begin
            armed_r <= armed_r;
        end
    end

    // TX buffer: a local write always wins over the empty flag set by a reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_buf_r   <= {WIDTH{1'b0}};
            tx_ready_r <= 1'b1;
        end else if (bus.DATA_LOAD) begin
            tx_buf_r   <= bus.data_TX;
            tx_ready_r <= 1'b0;
        end else if (reload_s) begin
            tx_ready_r <= 1'b1;
        end else begin
            tx_ready_r <= tx_ready_r;
        end
    end

    // Shift registers, bit counter, captured mode and shift-skip flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sr_r   <= {WIDTH{1'b0}};
            rx_sr_r   <= {(WIDTH-1){1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            ckp_r     <= 1'b0;
            cke_r     <= 1'b0;
            skip_r    <= 1'b0;
        end else if (cs_accept_s) begin
            tx_sr_r   <= tx_fill_s;
            bit_cnt_r <= {CNT_W{1'b0}};
            ckp_r     <= bus.CKP;
            cke_r     <= bus.CKE;
            // CKE=1 presents bit 7 already, so its first leading edge must not shift.
            skip_r    <= bus.CKE;
        end else if (abort_s) begin
            bit_cnt_r <= {CNT_W{1'b0}};
        end else if (sample_do_s) begin
            rx_sr_r   <= {rx_sr_r[WIDTH-3:0], mosi_q_s};
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            if (byte_done_s) begin
                tx_sr_r <= tx_fill_s;
                skip_r  <= 1'b1;
            end else begin
                tx_sr_r <= tx_sr_r;
            end
        end else if (shift_do_s) begin
            if (skip_r) begin
                skip_r <= 1'b0;
            end else begin
                tx_sr_r <= {tx_sr_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            tx_sr_r <= tx_sr_r;
        end
    end

    // Registered outputs towards pins and local logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_rx_r   <= {WIDTH{1'b0}};
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            miso_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (byte_done_s) begin
                data_rx_r <= {rx_sr_r, mosi_q_s};
            end else begin
                data_rx_r <= data_rx_r;
            end
            rx_valid_r  <= byte_done_s;
            frame_err_r <= abort_s;
            miso_r      <= (state_r == ACTIVE) ? tx_sr_r[WIDTH-1] : 1'b0;
            busy_r      <= (state_next == ACTIVE);
        end
    end

    assign bus.MISO      = miso_r;
    assign bus.TX_READY  = tx_ready_r;
    assign bus.data_RX   = data_rx_r;
    assign bus.RX_VALID  = rx_valid_r;
    assign bus.FRAME_ERR = frame_err_r;
    assign bus.BUSY      = busy_r;

endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

Byte-oriented SPI slave: the peripheral-side counterpart of `SPI_Master_Top`, sharing its CS/SCLK/MOSI/MISO pins and CKP/CKE mode convention. It oversamples SCLK, CS and MOSI on the system clock, shifts MISO out MSB-first and assembles MOSI bytes MSB-first. Received bytes are handed to local logic with a one-cycle strobe, and a one-byte transmit buffer is loaded from local logic.

## Interface
Parameters:
- `WIDTH`, 8: frame length in bits. Only 8 is supported.

Ports:
- `clk`  in  1  system clock; one clock for the whole block.
- `rst`  in  1  reset; synchronous, active-high.
- `CKP`  in  1  SCLK idle level.
- `CKE`  in  1  phase select: 0 = sample on leading edge, 1 = sample on trailing edge.
- `CS`  in  1  chip select, active low, asynchronous to `clk`.
- `SCLK`  in  1  serial clock, asynchronous to `clk`.
- `MOSI`  in  1  serial data in.
- `MISO`  out  1  serial data out, registered.
- `data_TX`  in  8  byte to transmit.
- `DATA_LOAD`  in  1  1-cycle write strobe for `data_TX` into the TX buffer.
- `TX_READY`  out  1  TX buffer empty, ready for a new byte.
- `data_RX`  out  8  last complete received byte; held until the next one completes.
- `RX_VALID`  out  1  1-cycle pulse when `data_RX` updates.
- `FRAME_ERR`  out  1  1-cycle pulse when CS rises with a partial byte.
- `BUSY`  out  1  high in state ACTIVE.

## Operation
- **Synchronisation:** SCLK, CS and MOSI each pass through a 2-flop synchronizer, then an edge detector.
- **Edge naming:** leading edge = SCLK leaving level CKP; trailing edge = SCLK returning to CKP.
- **Edge roles:**
  - Sample edge = leading edge if CKE=0, trailing edge if CKE=1.
  - Shift edge = the other edge.
  - Net effect: sampling happens on rising SCLK when CKP==CKE and on falling SCLK otherwise.
- **Mode capture:** CKP and CKE are latched on CS fall. Changes during a frame are ignored.
- **State IDLE:**
  - `MISO`=0, `BUSY`=0.
  - On a qualified synced CS fall: tx_sr ← TX buffer (0x00 if empty), TX_READY←1, bit count ←0, go to ACTIVE.
- **State ACTIVE:**
  - `MISO` = tx_sr[7].
  - Sample edge: rx_sr ← {rx_sr[6:0], MOSI_sync}; count+1.
  - On the 8th sample edge:
    - data_RX ← assembled byte, RX_VALID pulses, count ←0.
    - tx_sr reloads from the TX buffer (0x00 if empty), TX_READY←1.
  - Shift edge, CKE=0: tx_sr shifts left, except that the shift edge after a reload is skipped.
  - Shift edge, CKE=1: tx_sr shifts left, except for the first shift edge of each byte, because bit 7 is already presented.
  - CS rise, count==0: go to IDLE silently.
  - CS rise, count≠0: pulse FRAME_ERR, discard the partial byte (data_RX unchanged), go to IDLE.
- **Multi-byte frames:** while CS stays low, bytes continue back-to-back.
- **TX buffer rules:**
  - DATA_LOAD writes the buffer and clears TX_READY.
  - A write while TX_READY=0 overwrites the buffer; last write wins.
  - DATA_LOAD in the same cycle as a reload: the reload takes the old content, the new byte is stored, TX_READY ends at 0.
- **CS arming:**
  - CS synchronizer flops reset to 1.
  - An `armed` flag clears on reset and sets after synced CS is seen high for at least 1 cycle.
  - A CS fall is accepted only while armed, so a reset mid-frame waits for CS to go high, then low again.

## Timing
- **Reset values:**
  - MISO=0, TX_READY=1, data_RX=0x00, RX_VALID=0, FRAME_ERR=0, BUSY=0.
  - TX buffer=0x00, state=IDLE.
- **Pin-to-action latency:** a pin edge acts 3 clk cycles later (2 sync + 1 detect). MISO updates 1 cycle after that.
- **RX_VALID:** asserted in cycle 4 after the 8th sample-edge pin transition.
- **Master constraints:**
  - SCLK half-period ≥ 4 clk.
  - CS fall to first SCLK edge ≥ 5 clk.
  - Last SCLK edge to CS rise ≥ 4 clk.
- **CKE=0:** MISO valid ≤ 4 clk after CS fall, before the first sample edge.
- **Priority within a cycle:** rst > CS rise > sample edge > shift edge. A sample and a shift edge cannot share a cycle under the constraints above.

## Structure
- **Shared package `spi_pkg`:**
  - State encoding: IDLE=1'b0, ACTIVE=1'b1.
  - Mode constants IDEAL_ZERO_NORMAL_PHASE … IDEAL_ONE_INVERTED_PHASE, matching the master's `{CKE,CKP}` encoding.
  - `SPI_WIDTH`=8.
- **Sub-module `spi_sync_edge`:** 2-flop synchronizer plus rise/fall detect, with a parameterised reset value. Instantiated three times.

## Test plan
- **Mode 00 exchange:** master with Div=4 sends 0xF8, buffer loaded 0xC3 → data_RX=0xF8 with one RX_VALID; master receives 0xC3.
- **Remaining modes:**
  - Mode 01: 0x3E/0x6C.
  - Mode 10: 0xAA/0x55.
  - Mode 11: 0xFE/0x26.
  - Each exchanges correctly; also repeat mode 11 and mode 01 with Div=8.
- **Two-byte frame:** CS held low, buffer 0x11 then DATA_LOAD 0x22 during byte 1; master sends 0xA5, 0x5A → two RX_VALIDs with 0xA5, 0x5A; master receives 0x11, 0x22; TX_READY=1 after each reload.
- **Empty buffer:** no DATA_LOAD before the frame → slave transmits 0x00; TX_READY stays 1.
- **Aborted frame:** CS raised after 5 SCLK cycles → FRAME_ERR pulses once, no RX_VALID, data_RX keeps its previous value; the next full frame works.
- **Reset mid-frame:** rst asserted after 3 bits with CS still low → outputs at reset values, BUSY=0. No activity until CS goes high then low; the subsequent frame is correct.
